// File: rtl/scig_cif_0_1_div_32s_16ns_seq.sv
// Sequential radix-2 restoring divider: signed 32-bit dividend by unsigned 16-bit divisor.
// Truncated signed quotient and remainder (sign of the remainder follows the dividend),
// one quotient bit per enabled cycle, start/done handshake, fixed 33-cycle latency.
module scig_cif_0_1_div_32s_16ns_seq #(
  parameter int unsigned din0_WIDTH = 32,
  parameter int unsigned din1_WIDTH = 16,
  parameter int unsigned dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  div_by_zero
);

  localparam int unsigned CntW = $clog2(din0_WIDTH);
  localparam int unsigned RemW = din1_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e                state_q, state_d;
  logic [din0_WIDTH-1:0] mag_q, mag_d;
  logic                  neg_q, neg_d;
  logic [din1_WIDTH-1:0] dvs_q, dvs_d;
  logic                  zero_q, zero_d;
  logic [RemW-1:0]       r_q, r_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [RemW-1:0]       rem_q, rem_d;
  logic                  dbz_q, dbz_d;

  // |din0| as unsigned; -2^31 maps to 2^31, which still fits in 32 bits.
  logic [din0_WIDTH-1:0] din0_abs;
  assign din0_abs = din0[din0_WIDTH-1] ? (~din0 + 1'b1) : din0;

  // Trial subtraction one bit wider than the shifted remainder; the MSB is the borrow.
  logic [RemW:0] trial;
  logic          qbit;
  assign trial = {1'b0, r_q[din1_WIDTH-1:0], mag_q[din0_WIDTH-1]} - {2'b00, dvs_q};
  assign qbit  = ~trial[RemW];

  // Next-state logic: accept, iterate, then sign-correct and publish.
  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    dvs_d   = dvs_q;
    zero_d  = zero_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          mag_d   = din0_abs;
          neg_d   = din0[din0_WIDTH-1];
          dvs_d   = din1;
          zero_d  = (din1 == '0);
          r_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = StCalc;
        end
      end
      StCalc: begin
        r_d   = qbit ? trial[RemW-1:0] : {r_q[din1_WIDTH-1:0], mag_q[din0_WIDTH-1]};
        mag_d = {mag_q[din0_WIDTH-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(din0_WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        if (zero_q) begin
          // Saturate toward the sign of the dividend.
          dout_d = neg_q ? {1'b1, {(dout_WIDTH-1){1'b0}}} : {1'b0, {(dout_WIDTH-1){1'b1}}};
          rem_d  = '0;
          dbz_d  = 1'b1;
        end else begin
          dout_d = neg_q ? (~mag_q + 1'b1) : mag_q;
          rem_d  = neg_q ? (~r_q + 1'b1) : r_q;
          dbz_d  = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State register: synchronous reset, everything frozen while ce is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      dvs_q   <= '0;
      zero_q  <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      dvs_q   <= dvs_d;
      zero_q  <= zero_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_scig_cif_0_1_div_32s_16ns_seq.sv
// Bench for the sequential signed/unsigned divider: scoreboard of expected results,
// one task per scenario, all sampling on the falling clock edge.
module tb_scig_cif_0_1_div_32s_16ns_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        start;
  logic [31:0] din0;
  logic [15:0] din1;
  logic        busy;
  logic        done;
  logic [31:0] dout;
  logic [16:0] rem;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] q;
    logic [16:0] r;
    logic        z;
  } exp_t;

  exp_t sb[$];

  scig_cif_0_1_div_32s_16ns_seq #(
    .din0_WIDTH(32),
    .din1_WIDTH(16),
    .dout_WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ce         (ce),
    .start      (start),
    .din0       (din0),
    .din1       (din1),
    .busy       (busy),
    .done       (done),
    .dout       (dout),
    .rem        (rem),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: truncating 64-bit signed division.
  function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
    exp_t   e;
    longint la, lb, qq, rr;
    la = longint'($signed(a));
    lb = {48'd0, b};
    if (b == 16'd0) begin
      e.q = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.r = 17'd0;
      e.z = 1'b1;
    end else begin
      qq  = la / lb;
      rr  = la % lb;
      e.q = qq[31:0];
      e.r = rr[16:0];
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Call at a falling edge with the block idle and ce high.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    din0  = a;
    din1  = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts clocks after the accepting edge until done is seen at a falling edge.
  task automatic wait_done(input int limit, output int cycles, output int busy_cnt,
                           output bit timed_out);
    cycles    = 0;
    busy_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      cycles++;
      if (busy === 1'b1) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    ce    = 1'b1;
    start = 1'b0;
    din0  = '0;
    din1  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset done got=%b exp=0", done); end
    n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL reset dout got=%h exp=0", dout); end
    n_cmp++; if (rem !== 17'd0) begin n_err++; $display("FAIL reset rem got=%h exp=0", rem); end
    n_cmp++;
    if (div_by_zero !== 1'b0) begin
      n_err++; $display("FAIL reset div_by_zero got=%b exp=0", div_by_zero);
    end
  endtask

  // Arithmetic results, latency, busy width and one-cycle done pulse.
  task automatic test_arith;
    logic [31:0] va[9];
    logic [15:0] vb[9];
    int c, bc;
    bit to;
    exp_t e;
    va[0] = 32'd100;        vb[0] = 16'd7;
    va[1] = -32'sd100;      vb[1] = 16'd7;
    va[2] = 32'h8000_0000;  vb[2] = 16'd1;
    va[3] = 32'h7FFF_FFFF;  vb[3] = 16'd65535;
    va[4] = 32'd5;          vb[4] = 16'd9;
    for (int i = 5; i < 9; i++) begin
      va[i] = $urandom;
      vb[i] = 16'($urandom_range(1, 65535));
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start_op(va[i], vb[i]);
      wait_done(100, c, bc, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL arith[%0d] done timeout", i); end
      n_cmp++;
      if (c != 33) begin n_err++; $display("FAIL arith[%0d] latency got=%0d exp=33", i, c); end
      n_cmp++;
      if (bc != 33) begin n_err++; $display("FAIL arith[%0d] busy cycles got=%0d exp=33", i, bc); end
      n_cmp++;
      if (dout !== e.q) begin n_err++; $display("FAIL arith[%0d] dout got=%h exp=%h", i, dout, e.q); end
      n_cmp++;
      if (rem !== e.r) begin n_err++; $display("FAIL arith[%0d] rem got=%h exp=%h", i, rem, e.r); end
      n_cmp++;
      if (div_by_zero !== e.z) begin
        n_err++; $display("FAIL arith[%0d] div_by_zero got=%b exp=%b", i, div_by_zero, e.z);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL arith[%0d] done pulse got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_div_zero;
    logic [31:0] va[3];
    logic [15:0] vb[3];
    int c, bc;
    bit to;
    exp_t e;
    va[0] = 32'd123; vb[0] = 16'd0;
    va[1] = 32'hFFFF_FFFF; vb[1] = 16'd0;
    va[2] = 32'd8; vb[2] = 16'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start_op(va[i], vb[i]);
      wait_done(100, c, bc, to);
      e = sb.pop_front();
      n_cmp++; if (to) begin n_err++; $display("FAIL dbz[%0d] done timeout", i); end
      n_cmp++;
      if (c != 33) begin n_err++; $display("FAIL dbz[%0d] latency got=%0d exp=33", i, c); end
      n_cmp++;
      if (dout !== e.q) begin n_err++; $display("FAIL dbz[%0d] dout got=%h exp=%h", i, dout, e.q); end
      n_cmp++;
      if (rem !== e.r) begin n_err++; $display("FAIL dbz[%0d] rem got=%h exp=%h", i, rem, e.r); end
      n_cmp++;
      if (div_by_zero !== e.z) begin
        n_err++; $display("FAIL dbz[%0d] div_by_zero got=%b exp=%b", i, div_by_zero, e.z);
      end
    end
  endtask

  // ce stalls mid-calculation and while done is high; a start while busy is ignored.
  task automatic test_stall;
    int c, bc, held;
    bit to;
    exp_t e;
    @(negedge clk);
    start_op(32'd1000, 16'd7);
    repeat (5) @(negedge clk);
    din0  = 32'd999;
    din1  = 16'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    ce = 1'b0;
    repeat (5) @(negedge clk);
    ce = 1'b1;
    wait_done(100, c, bc, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL stall done timeout"); end
    n_cmp++;
    if (c + 15 != 38) begin n_err++; $display("FAIL stall latency got=%0d exp=38", c + 15); end
    n_cmp++; if (dout !== e.q) begin n_err++; $display("FAIL stall dout got=%h exp=%h", dout, e.q); end
    n_cmp++; if (rem !== e.r) begin n_err++; $display("FAIL stall rem got=%h exp=%h", rem, e.r); end
    ce   = 1'b0;
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) held++;
    end
    ce = 1'b1;
    n_cmp++; if (held != 5) begin n_err++; $display("FAIL stall done hold got=%0d exp=5", held); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL stall done fall got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stall busy got=%b exp=0", busy); end
  endtask

  // Reset during calculation: no completion, outputs cleared.
  task automatic test_abort;
    int seen;
    @(negedge clk);
    start_op(32'd1000, 16'd10);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort done got=%b exp=0", done); end
    n_cmp++; if (dout !== 32'd0) begin n_err++; $display("FAIL abort dout got=%h exp=0", dout); end
    n_cmp++; if (rem !== 17'd0) begin n_err++; $display("FAIL abort rem got=%h exp=0", rem); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort stray done got=%0d exp=0", seen); end
  endtask

  // Start issued in the done cycle is accepted immediately.
  task automatic test_back_to_back;
    int c, bc;
    bit to;
    exp_t e;
    @(negedge clk);
    start_op(32'd17, 16'd5);
    wait_done(100, c, bc, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b first timeout"); end
    n_cmp++; if (dout !== e.q) begin n_err++; $display("FAIL b2b first dout got=%h exp=%h", dout, e.q); end
    start_op(32'd9, 16'd3);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b done fall got=%b exp=0", done); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b accept busy got=%b exp=1", busy); end
    wait_done(100, c, bc, to);
    e = sb.pop_front();
    n_cmp++; if (to) begin n_err++; $display("FAIL b2b second timeout"); end
    n_cmp++; if (c != 33) begin n_err++; $display("FAIL b2b latency got=%0d exp=33", c); end
    n_cmp++; if (dout !== e.q) begin n_err++; $display("FAIL b2b dout got=%h exp=%h", dout, e.q); end
    n_cmp++; if (rem !== e.r) begin n_err++; $display("FAIL b2b rem got=%h exp=%h", rem, e.r); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_zero();
    test_stall();
    test_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
